bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  Parametrised round-robin bus arbiter for NUM_MASTERS bus masters; next generation of the 4-master arbiter.
//  Grants exactly one master at all times (parks on last owner), rotates fairly, and adds a max-hold
//  preemption counter, per-master bus lock and owner/preempt status outputs. Sits between masters and bus mux.
// PARAMETERS
//  NUM_MASTERS  4    number of masters, 2..16, need not be a power of two
//  OWNER_W      2    width of owner index, = clog2(NUM_MASTERS)
//  MAX_HOLD     16   max consecutive grant cycles under contention; 0 = unlimited (no preemption)
//  HOLD_W       5    hold counter width, = clog2(MAX_HOLD+1)
//  RESET_OWNER  0    owner index loaded on reset, < NUM_MASTERS
// PORTS
//  clk       in   1            clock
//  reset     in   1            asynchronous reset, active-high
//  m_req_    in   NUM_MASTERS  bus request per master, active-low
//  m_lock_   in   NUM_MASTERS  lock request per master, active-low; honoured only for current owner
//  m_grnt_   out  NUM_MASTERS  bus grant per master, active-low, one-hot-low
//  owner     out  OWNER_W      index of current owner (registered)
//  preempt   out  1            active-high one-cycle pulse: previous edge performed a forced rotation
// BEHAVIOUR
//  Reset (async, immediate): owner=RESET_OWNER; hold_cnt=0; preempt=0; m_grnt_ = all 1 except bit RESET_OWNER = 0.
//  m_grnt_ is combinational decode of owner: exactly one bit low every cycle incl. reset and idle.
//  Internal hold_cnt [HOLD_W]: cycles current owner has been retained with own request asserted.
//  At each posedge clk, with req = ~m_req_, oreq = req[owner], lock = ~m_lock_[owner] & oreq,
//  others = |(req with owner bit cleared):
//   - KEEP: oreq & (MAX_HOLD==0 | !others | lock | hold_cnt < MAX_HOLD-1):
//     owner unchanged; hold_cnt <= saturating hold_cnt+1 (cap MAX_HOLD-1); preempt <= 0.
//   - ROTATE: otherwise, if others: owner <= first requesting index scanning owner+1, owner+2, ...
//     cyclically, wrapping NUM_MASTERS-1 -> 0; hold_cnt <= 0; preempt <= oreq (1 only if forced).
//   - PARK: !oreq & !others: owner unchanged; hold_cnt <= 0; preempt <= 0.
//  Latency: request sampled at edge k -> grant visible after edge k (one clock); release likewise.
//  Under contention an unlocked owner holds grant exactly MAX_HOLD cycles, then passes to next requester.
//  MAX_HOLD=1: rotation every cycle under contention. Locked owner is never preempted; lock without
//  request is ignored; non-owner lock bits are ignored.
//  Owner dropping request with others pending: normal rotation, preempt stays 0.
//  Simultaneous new requests: cyclic scan order from owner+1 decides; owner itself is considered last.
//  Indices >= NUM_MASTERS never produced; owner register never holds an out-of-range value.
//  Reset mid-transfer: grant returns to RESET_OWNER immediately, counter cleared, no preempt pulse.
// TESTING
//  1 Reset, no requests (N=4,RESET_OWNER=0) -> m_grnt_=4'b1110, owner=0, preempt=0, stays parked.
//  2 m_req_=4'b1011 (master 2) from owner 0 -> one edge later owner=2, m_grnt_=4'b1011; release -> parks on 2.
//  3 All four request continuously, MAX_HOLD=4 -> owner 0,1,2,3,0 each held 4 cycles, preempt pulses at each change.
//  4 As 3 but master 1 asserts m_lock_ while owner -> holds indefinitely, no preempt; lock off -> passes to 2 after cap.
//  5 N=5, owner=4, req from masters 0 and 3 -> wrap scan grants 0; then 3 on next rotation.
//  6 Reset asserted mid-hold with owner=2, hold_cnt=3 -> immediately owner=0, grant bit0 low, preempt=0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: parks on the last owner, rotates fairly, caps hold time
// under contention and honours a bus lock from the current owner.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2,
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_W      = 5,
  parameter int RESET_OWNER = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req_,
  input  logic [NUM_MASTERS-1:0] m_lock_,
  output logic [NUM_MASTERS-1:0] m_grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   preempt
);

  // With MAX_HOLD=0 the counter is never compared, so keep it at least one bit wide.
  localparam int CNT_W    = (HOLD_W < 1) ? 1 : HOLD_W;
  localparam int HOLD_CAP = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  logic [CNT_W-1:0]       hold_cnt;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] others_req;
  logic                   oreq;
  logic                   lock;
  logic                   others;
  logic                   keep;
  logic [OWNER_W-1:0]     next_owner;
  int                     scan_sum;

  always_comb begin
    // NOTE: every signal gets a value before any conditional write, so no latch is inferred.
    req        = ~m_req_;
    oreq       = req[owner];
    lock       = ~m_lock_[owner] & oreq;
    others_req = req;
    others_req[owner] = 1'b0;
    others     = |others_req;
    keep       = oreq & ((MAX_HOLD == 0) || !others || lock ||
                         (int'(hold_cnt) < MAX_HOLD - 1));
  end

  // Scan from farthest to nearest so the nearest requester after the owner wins.
  always_comb begin
    next_owner = owner;
    scan_sum   = 0;
    for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
      scan_sum = int'(owner) + k;
      if (scan_sum >= NUM_MASTERS) scan_sum = scan_sum - NUM_MASTERS;
      if (req[scan_sum]) next_owner = OWNER_W'(scan_sum);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= OWNER_W'(RESET_OWNER);
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else if (keep) begin
      hold_cnt <= (int'(hold_cnt) >= HOLD_CAP) ? CNT_W'(HOLD_CAP) : hold_cnt + 1'b1;
      preempt  <= 1'b0;
    end else if (others) begin
      owner    <= next_owner;
      hold_cnt <= '0;
      preempt  <= oreq;
    end else begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end
  end

  always_comb begin
    m_grnt_        = '1;
    m_grnt_[owner] = 1'b0;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a 4-master (MAX_HOLD=4) and a 5-master
// (MAX_HOLD=1, RESET_OWNER=4) instance checked against a spec-level model.
module tb_bus_arbiter_rr;

  localparam int A_HOLD = 4;
  localparam int B_HOLD = 1;
  localparam int B_RST  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a_req_, a_lock_, a_grnt_;
  logic [1:0] a_owner;
  logic       a_preempt;
  logic [4:0] b_req_, b_lock_, b_grnt_;
  logic [2:0] b_owner;
  logic       b_preempt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int a_own;
    int a_pre;
    int b_own;
    int b_pre;
  } exp_t;

  exp_t sb[$];

  int a_own, a_hold, a_pre;
  int b_own, b_hold, b_pre;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(A_HOLD), .HOLD_W(3), .RESET_OWNER(0)) dut_a (
    .clk(clk), .reset(reset), .m_req_(a_req_), .m_lock_(a_lock_),
    .m_grnt_(a_grnt_), .owner(a_owner), .preempt(a_preempt)
  );

  bus_arbiter_rr #(.NUM_MASTERS(5), .OWNER_W(3), .MAX_HOLD(B_HOLD), .HOLD_W(1), .RESET_OWNER(B_RST)) dut_b (
    .clk(clk), .reset(reset), .m_req_(b_req_), .m_lock_(b_lock_),
    .m_grnt_(b_grnt_), .owner(b_owner), .preempt(b_preempt)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester after own in cyclic order; own itself is considered last.
  function automatic int rr_next(int own, logic [15:0] req, int n);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (own + k) % n;
      if (req[i]) return i;
    end
    return own;
  endfunction

  task automatic model_step(input int n, input int max_hold, input logic [15:0] req,
                            input logic [15:0] lck, inout int own, inout int hold, inout int pre);
    logic [15:0] oth;
    logic        oreq, lock;
    oreq = req[own];
    lock = oreq & lck[own];
    oth  = req;
    oth[own] = 1'b0;
    if (oreq && (max_hold == 0 || oth == 0 || lock || hold < max_hold - 1)) begin
      hold = (max_hold > 0 && hold >= max_hold - 1) ? max_hold - 1 : hold + 1;
      pre  = 0;
    end else if (oth != 0) begin
      own  = rr_next(own, oth, n);
      hold = 0;
      pre  = oreq ? 1 : 0;
    end else begin
      hold = 0;
      pre  = 0;
    end
  endtask

  function automatic int grant_of(int own, int n);
    return ((1 << n) - 1) & ~(1 << own);
  endfunction

  // Inputs are active-high here; the task drives the active-low ports.
  task automatic drive(logic [3:0] ar, logic [3:0] al, logic [4:0] br, logic [4:0] bl);
    exp_t e;
    @(negedge clk);
    a_req_  = ~ar;
    a_lock_ = ~al;
    b_req_  = ~br;
    b_lock_ = ~bl;
    model_step(4, A_HOLD, 16'(ar), 16'(al), a_own, a_hold, a_pre);
    model_step(5, B_HOLD, 16'(br), 16'(bl), b_own, b_hold, b_pre);
    e.a_own = a_own;
    e.a_pre = a_pre;
    e.b_own = b_own;
    e.b_pre = b_pre;
    sb.push_back(e);
  endtask

  // Asserted between edges after the monitor has drained the scoreboard.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_a_owner", 32'(a_owner), 0);
    check("rst_a_grnt", 32'(a_grnt_), 32'b1110);
    check("rst_a_preempt", 32'(a_preempt), 0);
    check("rst_b_owner", 32'(b_owner), B_RST);
    check("rst_b_grnt", 32'(b_grnt_), 32'b01111);
    check("rst_b_preempt", 32'(b_preempt), 0);
    a_own = 0;     a_hold = 0; a_pre = 0;
    b_own = B_RST; b_hold = 0; b_pre = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("a_owner", 32'(a_owner), e.a_own);
      check("a_grnt", 32'(a_grnt_), grant_of(e.a_own, 4));
      check("a_preempt", 32'(a_preempt), e.a_pre);
      check("b_owner", 32'(b_owner), e.b_own);
      check("b_grnt", 32'(b_grnt_), grant_of(e.b_own, 5));
      check("b_preempt", 32'(b_preempt), e.b_pre);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    a_req_  = '1;
    a_lock_ = '1;
    b_req_  = '1;
    b_lock_ = '1;
    a_own = 0;     a_hold = 0; a_pre = 0;
    b_own = B_RST; b_hold = 0; b_pre = 0;
    #1;
    check("por_a_grnt", 32'(a_grnt_), 32'b1110);
    check("por_b_grnt", 32'(b_grnt_), 32'b01111);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Idle: both stay parked on their reset owner.
    repeat (3) drive('0, '0, '0, '0);
    @(posedge clk); #2;
    check("idle_a_owner", 32'(a_owner), 0);
    check("idle_b_owner", 32'(b_owner), B_RST);

    // Single request from master 2 on A; masters 0 and 3 on B from owner 4 (wrap).
    drive(4'b0100, '0, 5'b01001, '0);
    @(posedge clk); #2;
    check("req2_a_owner", 32'(a_owner), 2);
    check("req2_a_grnt", 32'(a_grnt_), 32'b1011);
    check("wrap_b_owner", 32'(b_owner), 0);
    check("wrap_b_preempt", 32'(b_preempt), 0);
    drive('0, '0, 5'b01001, '0);
    @(posedge clk); #2;
    check("park_a_owner", 32'(a_owner), 2);
    check("next_b_owner", 32'(b_owner), 3);
    check("next_b_preempt", 32'(b_preempt), 1);
    drive('0, '0, '0, '0);

    // Full contention on A with MAX_HOLD=4.
    do_reset();
    repeat (4) drive(4'b1111, '0, 5'b11111, '0);
    @(posedge clk); #2;
    check("cont_a_owner4", 32'(a_owner), 1);
    check("cont_a_preempt4", 32'(a_preempt), 1);
    repeat (12) drive(4'b1111, '0, 5'b11111, '0);
    @(posedge clk); #2;
    check("cont_a_owner16", 32'(a_owner), 0);

    // Master 1 locks while owner: never preempted; lock off -> passes to 2 at once.
    repeat (16) drive(4'b1111, 4'b0010, $urandom, $urandom);
    @(posedge clk); #2;
    check("lock_a_owner", 32'(a_owner), 1);
    check("lock_a_preempt", 32'(a_preempt), 0);
    drive(4'b1111, '0, '0, '0);
    @(posedge clk); #2;
    check("unlock_a_owner", 32'(a_owner), 2);
    check("unlock_a_preempt", 32'(a_preempt), 1);

    // Reset mid-hold: owner 2 with hold count 3, request still asserted.
    do_reset();
    repeat (4) drive(4'b0100, '0, '0, '0);
    @(posedge clk); #2;
    check("midhold_a_owner", 32'(a_owner), 2);
    do_reset();
    repeat (2) drive(4'b0100, '0, '0, '0);

    // Randomised traffic with sparse locks and an occasional reset.
    for (int c = 0; c < 400; c++) begin
      logic [3:0] ar, al;
      logic [4:0] br, bl;
      ar = 4'($urandom);
      br = 5'($urandom);
      al = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bl = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
      if (c == 200) do_reset();
      drive(ar, al, br, bl);
    end

    @(posedge clk); #2;
    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
